// File: rtl/aes_io_pkg.sv
// Shared types and constants for the AES host-side UART block receiver.
// UART_RX_PARITY_EN adds an even-parity bit to each frame.
package aes_io_pkg;

  localparam logic [7:0] CMD_KEY = 8'h4B;
  localparam logic [7:0] CMD_PT  = 8'h50;
  localparam int BLOCK_BYTES = 16;
  localparam int BLOCK_W = BLOCK_BYTES * 8;

`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  typedef enum logic [2:0] {
    B_IDLE,
    B_START,
    B_DATA,
`ifdef UART_RX_PARITY_EN
    B_PARITY,
`endif
    B_STOP
  } bit_state_t;

  typedef enum logic [1:0] {
    F_WAIT_CMD,
    F_LOAD,
    F_HOLD
  } frame_state_t;

endpackage

// File: rtl/uart_block_rx_if.sv
// Block handshake between the UART receiver and the AES core.
// Master presents the block, slave returns ready.
interface uart_block_rx_if;
  import aes_io_pkg::*;

  logic               blk_valid;
  logic               blk_ready;
  logic [BLOCK_W-1:0] blk_data;
  logic               blk_is_key;

  modport master (
    output blk_valid,
    output blk_data,
    output blk_is_key,
    input  blk_ready
  );

  modport slave (
    input  blk_valid,
    input  blk_data,
    input  blk_is_key,
    output blk_ready
  );

endinterface

// File: rtl/uart_rx_byte.sv
// Pad synchroniser and UART bit FSM; emits one byte per good frame.
// UART_RX_PARITY_EN enables the even-parity check before the stop bit.
module uart_rx_byte
  import aes_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       io_clk,
  input  logic       io_reset,
  input  logic       io_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_byte_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    r_sync;
  logic          r_prev;
  bit_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;

  logic w_rx;
  logic w_fall;
  logic w_wrap;
  logic w_par_ok;

  assign w_rx   = r_sync[1];
  assign w_fall = r_prev & ~w_rx;
  assign w_wrap = (r_cnt == FULL_M1);

`ifdef UART_RX_PARITY_EN
  logic r_par_ok;
  assign w_par_ok = r_par_ok;
`else
  assign w_par_ok = 1'b1;
`endif

  always_ff @(posedge io_clk or negedge io_reset) begin
    if (!io_reset) begin
      r_sync       <= 2'b11;
      r_prev       <= 1'b1;
      r_state      <= B_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      o_byte       <= '0;
      o_byte_valid <= 1'b0;
      o_byte_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_ok     <= 1'b1;
`endif
    end else begin
      r_sync       <= {r_sync[0], io_rx};
      r_prev       <= w_rx;
      o_byte_valid <= 1'b0;
      o_byte_err   <= 1'b0;
      r_cnt        <= w_wrap ? '0 : r_cnt + 1'b1;
      unique case (r_state)
        B_IDLE: begin
          r_cnt <= '0;
          if (w_fall) r_state <= B_START;
        end
        B_START: begin
          // a start bit that is high again at mid-bit was a glitch
          if (r_cnt == HALF_M1) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= w_rx ? B_IDLE : B_DATA;
          end
        end
        B_DATA: begin
          if (w_wrap) begin
            r_shift <= {w_rx, r_shift[7:1]};
            r_bit   <= r_bit + 1'b1;
            if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= B_PARITY;
`else
              r_state <= B_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        B_PARITY: begin
          if (w_wrap) begin
            r_par_ok <= (w_rx == ^r_shift);
            r_state  <= B_STOP;
          end
        end
`endif
        B_STOP: begin
          // leave at mid-stop so the next start edge is caught
          if (w_wrap) begin
            r_state <= B_IDLE;
            if (w_rx && w_par_ok) begin
              o_byte       <= r_shift;
              o_byte_valid <= 1'b1;
            end else begin
              o_byte_err   <= 1'b1;
            end
          end
        end
        default: r_state <= B_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_block_rx.sv
// Assembles 'K'/'P' framed UART commands into 128-bit AES blocks.
// UART_RX_PARITY_EN selects 8E1 framing and an 11-bit timeout unit.
module uart_block_rx
  import aes_io_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 16,
  parameter int TIMEOUT_BYTES = 4
) (
  input  logic            io_clk,
  input  logic            io_reset,
  input  logic            io_rx,
  uart_block_rx_if.master blk,
  output logic            frame_err,
  output logic            cmd_err,
  output logic            overrun
);

  localparam int TO_LIMIT = TIMEOUT_BYTES * FRAME_BITS * CLKS_PER_BIT;
  localparam int TW = $clog2(TO_LIMIT + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TO_LIMIT);
  localparam logic [3:0] LAST = 4'(BLOCK_BYTES - 1);

  logic [7:0] w_byte;
  logic       w_byte_valid;
  logic       w_byte_err;

  frame_state_t       r_state;
  logic [3:0]         r_cnt;
  logic [TW-1:0]      r_to;
  logic [BLOCK_W-1:0] r_data;
  logic               r_key;
  logic               r_valid;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .io_clk      (io_clk),
    .io_reset    (io_reset),
    .io_rx       (io_rx),
    .o_byte      (w_byte),
    .o_byte_valid(w_byte_valid),
    .o_byte_err  (w_byte_err)
  );

  assign blk.blk_valid  = r_valid;
  assign blk.blk_data   = r_data;
  assign blk.blk_is_key = r_key;

  always_ff @(posedge io_clk or negedge io_reset) begin
    if (!io_reset) begin
      r_state   <= F_WAIT_CMD;
      r_cnt     <= '0;
      r_to      <= '0;
      r_data    <= '0;
      r_key     <= 1'b0;
      r_valid   <= 1'b0;
      frame_err <= 1'b0;
      cmd_err   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= w_byte_err;
      cmd_err   <= 1'b0;
      overrun   <= 1'b0;
      unique case (r_state)
        F_WAIT_CMD: begin
          r_cnt <= '0;
          r_to  <= '0;
          if (w_byte_valid) begin
            unique case (1'b1)
              (w_byte == CMD_KEY): begin
                r_key   <= 1'b1;
                r_state <= F_LOAD;
              end
              (w_byte == CMD_PT): begin
                r_key   <= 1'b0;
                r_state <= F_LOAD;
              end
              default: cmd_err <= 1'b1;
            endcase
          end
        end
        F_LOAD: begin
          // a delivered byte beats a simultaneous timeout
          if (w_byte_valid) begin
            r_data <= {r_data[BLOCK_W-9:0], w_byte};
            r_cnt  <= r_cnt + 1'b1;
            r_to   <= '0;
            if (r_cnt == LAST) begin
              r_state <= F_HOLD;
              r_valid <= 1'b1;
            end
          end else if (w_byte_err) begin
            r_state <= F_WAIT_CMD;
            r_cnt   <= '0;
            r_to    <= '0;
          end else if (r_to == TO_MAX) begin
            cmd_err <= 1'b1;
            r_state <= F_WAIT_CMD;
            r_cnt   <= '0;
            r_to    <= '0;
          end else begin
            r_to <= r_to + 1'b1;
          end
        end
        F_HOLD: begin
          if (w_byte_valid) overrun <= 1'b1;
          if (r_valid && blk.blk_ready) begin
            r_valid <= 1'b0;
            r_state <= F_WAIT_CMD;
          end
        end
        default: r_state <= F_WAIT_CMD;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_block_rx.sv
// Directed bench for uart_block_rx: one task per scenario.
// Expected blocks and flag counts are hand-computed constants.
module tb_uart_block_rx;

  localparam int CPB = 16;

  logic io_clk   = 1'b0;
  logic io_reset = 1'b0;
  logic io_rx    = 1'b1;
  logic frame_err;
  logic cmd_err;
  logic overrun;

  uart_block_rx_if bif();

  uart_block_rx #(
    .CLKS_PER_BIT (CPB),
    .TIMEOUT_BYTES(4)
  ) dut (
    .io_clk   (io_clk),
    .io_reset (io_reset),
    .io_rx    (io_rx),
    .blk      (bif),
    .frame_err(frame_err),
    .cmd_err  (cmd_err),
    .overrun  (overrun)
  );

  always #5 io_clk = ~io_clk;

  int checks = 0;
  int errors = 0;

  int n_fe   = 0;
  int n_ce   = 0;
  int n_ov   = 0;
  int n_vc   = 0;
  int n_acc  = 0;
  int n_unst = 0;
  logic [127:0] acc_data  = '0;
  logic         acc_key   = 1'b0;
  logic [127:0] prev_data = '0;
  logic         prev_v    = 1'b0;

  always @(negedge io_clk) begin
    if (io_reset) begin
      if (frame_err) n_fe <= n_fe + 1;
      if (cmd_err) n_ce <= n_ce + 1;
      if (overrun) n_ov <= n_ov + 1;
      if (bif.blk_valid) n_vc <= n_vc + 1;
      if (bif.blk_valid && bif.blk_ready) begin
        n_acc    <= n_acc + 1;
        acc_data <= bif.blk_data;
        acc_key  <= bif.blk_is_key;
      end
      if (bif.blk_valid && prev_v &&
          bif.blk_data !== prev_data)
        n_unst <= n_unst + 1;
      prev_v    <= bif.blk_valid;
      prev_data <= bif.blk_data;
    end
  end

  task automatic send_byte(input logic [7:0] d,
                           input logic stop_bit);
    io_rx = 1'b0;
    repeat (CPB) @(negedge io_clk);
    for (int i = 0; i < 8; i++) begin
      io_rx = d[i];
      repeat (CPB) @(negedge io_clk);
    end
`ifdef UART_RX_PARITY_EN
    io_rx = ^d;
    repeat (CPB) @(negedge io_clk);
`endif
    io_rx = stop_bit;
    repeat (CPB) @(negedge io_clk);
    io_rx = 1'b1;
  endtask

  task automatic settle();
    repeat (12) @(negedge io_clk);
  endtask

  task automatic test_reset();
    io_reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge io_clk);
      io_rx = ~io_rx;
    end
    @(negedge io_clk);
    checks++;
    if (bif.blk_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got %b want 0", bif.blk_valid);
    end
    checks++;
    if (bif.blk_data !== 128'h0) begin
      errors++;
      $display("FAIL rst_data got %h want 0", bif.blk_data);
    end
    checks++;
    if (bif.blk_is_key !== 1'b0) begin
      errors++;
      $display("FAIL rst_key got %b want 0", bif.blk_is_key);
    end
    checks++;
    if ({frame_err, cmd_err, overrun} !== 3'b000) begin
      errors++;
      $display("FAIL rst_flags got %b want 000",
               {frame_err, cmd_err, overrun});
    end
    io_rx = 1'b1;
    @(negedge io_clk);
    io_reset = 1'b1;
    repeat (50) @(negedge io_clk);
    checks++;
    if (n_fe + n_ce + n_ov !== 0) begin
      errors++;
      $display("FAIL rst_quiet got %0d pulses want 0",
               n_fe + n_ce + n_ov);
    end
    checks++;
    if (n_vc !== 0) begin
      errors++;
      $display("FAIL rst_novalid got %0d want 0", n_vc);
    end
  endtask

  task automatic test_key_block();
    int a0, v0, e0;
    bif.blk_ready = 1'b1;
    a0 = n_acc;
    v0 = n_vc;
    e0 = n_fe + n_ce + n_ov;
    send_byte(8'h4B, 1'b1);
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
    settle();
    checks++;
    if (n_acc - a0 !== 1) begin
      errors++;
      $display("FAIL key_accepts got %0d want 1", n_acc - a0);
    end
    checks++;
    if (n_vc - v0 !== 1) begin
      errors++;
      $display("FAIL key_vcycles got %0d want 1", n_vc - v0);
    end
    checks++;
    if (acc_data !== 128'h000102030405060708090a0b0c0d0e0f) begin
      errors++;
      $display("FAIL key_data got %h want 000102..0f", acc_data);
    end
    checks++;
    if (acc_key !== 1'b1) begin
      errors++;
      $display("FAIL key_flag got %b want 1", acc_key);
    end
    checks++;
    if (n_fe + n_ce + n_ov - e0 !== 0) begin
      errors++;
      $display("FAIL key_noerr got %0d want 0",
               n_fe + n_ce + n_ov - e0);
    end
  endtask

  task automatic test_backpressure();
    int o0, u0;
    bif.blk_ready = 1'b0;
    o0 = n_ov;
    u0 = n_unst;
    send_byte(8'h50, 1'b1);
    for (int i = 0; i < 16; i++) send_byte(8'hA5, 1'b1);
    settle();
    checks++;
    if (bif.blk_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_valid got %b want 1", bif.blk_valid);
    end
    checks++;
    if (bif.blk_data !== {16{8'hA5}}) begin
      errors++;
      $display("FAIL bp_data got %h want a5..a5", bif.blk_data);
    end
    checks++;
    if (bif.blk_is_key !== 1'b0) begin
      errors++;
      $display("FAIL bp_key got %b want 0", bif.blk_is_key);
    end
    send_byte(8'h11, 1'b1);
    settle();
    checks++;
    if (n_ov - o0 !== 1) begin
      errors++;
      $display("FAIL bp_overrun got %0d want 1", n_ov - o0);
    end
    checks++;
    if (bif.blk_valid !== 1'b1 || bif.blk_data !== {16{8'hA5}}) begin
      errors++;
      $display("FAIL bp_held got v=%b d=%h want v=1 a5..a5",
               bif.blk_valid, bif.blk_data);
    end
    checks++;
    if (n_unst - u0 !== 0) begin
      errors++;
      $display("FAIL bp_stable got %0d changes want 0", n_unst - u0);
    end
    #1 bif.blk_ready = 1'b1;
    @(negedge io_clk);
    checks++;
    if (bif.blk_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got %b want 0", bif.blk_valid);
    end
  endtask

  task automatic test_framing();
    int f0, c0, a0;
    bif.blk_ready = 1'b1;
    f0 = n_fe;
    c0 = n_ce;
    a0 = n_acc;
    send_byte(8'h50, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h5A, 1'b0);
    settle();
    checks++;
    if (n_fe - f0 !== 1) begin
      errors++;
      $display("FAIL fr_ferr got %0d want 1", n_fe - f0);
    end
    checks++;
    if (n_acc - a0 !== 0 || n_ce - c0 !== 0) begin
      errors++;
      $display("FAIL fr_noblk got acc=%0d ce=%0d want 0 0",
               n_acc - a0, n_ce - c0);
    end
    send_byte(8'h4B, 1'b1);
    for (int i = 0; i < 16; i++) send_byte(8'(8'hF0 + i), 1'b1);
    settle();
    checks++;
    if (n_acc - a0 !== 1) begin
      errors++;
      $display("FAIL fr_accept got %0d want 1", n_acc - a0);
    end
    checks++;
    if (acc_data !== 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff ||
        acc_key !== 1'b1) begin
      errors++;
      $display("FAIL fr_block got %h k=%b want f0..ff k=1",
               acc_data, acc_key);
    end
  endtask

  task automatic test_cmd_glitch();
    int f0, c0, o0, v0;
    bif.blk_ready = 1'b1;
    f0 = n_fe;
    c0 = n_ce;
    send_byte(8'h41, 1'b1);
    settle();
    checks++;
    if (n_ce - c0 !== 1) begin
      errors++;
      $display("FAIL cmd_err got %0d want 1", n_ce - c0);
    end
    checks++;
    if (n_fe - f0 !== 0) begin
      errors++;
      $display("FAIL cmd_noferr got %0d want 0", n_fe - f0);
    end
    f0 = n_fe;
    c0 = n_ce;
    o0 = n_ov;
    v0 = n_vc;
    io_rx = 1'b0;
    repeat (2) @(negedge io_clk);
    io_rx = 1'b1;
    repeat (3 * CPB) @(negedge io_clk);
    checks++;
    if (n_fe - f0 !== 0 || n_ce - c0 !== 0 || n_ov - o0 !== 0) begin
      errors++;
      $display("FAIL glitch_flags got fe=%0d ce=%0d ov=%0d want 0",
               n_fe - f0, n_ce - c0, n_ov - o0);
    end
    checks++;
    if (n_vc - v0 !== 0) begin
      errors++;
      $display("FAIL glitch_valid got %0d want 0", n_vc - v0);
    end
  endtask

  task automatic test_timeout();
    int f0, c0, v0;
    bif.blk_ready = 1'b1;
    f0 = n_fe;
    c0 = n_ce;
    v0 = n_vc;
    send_byte(8'h4B, 1'b1);
    for (int i = 0; i < 5; i++) send_byte(8'(8'h20 + i), 1'b1);
    repeat (5 * 10 * CPB) @(negedge io_clk);
    checks++;
    if (n_ce - c0 !== 1) begin
      errors++;
      $display("FAIL to_cmderr got %0d want 1", n_ce - c0);
    end
    checks++;
    if (n_fe - f0 !== 0 || n_vc - v0 !== 0) begin
      errors++;
      $display("FAIL to_quiet got fe=%0d v=%0d want 0 0",
               n_fe - f0, n_vc - v0);
    end
    send_byte(8'h00, 1'b1);
    settle();
    checks++;
    if (n_ce - c0 !== 2) begin
      errors++;
      $display("FAIL to_waitcmd got %0d want 2", n_ce - c0);
    end
`ifdef UART_RX_PARITY_EN
    f0 = n_fe;
    send_byte(8'h4B, 1'b1);
    io_rx = 1'b0;
    repeat (CPB) @(negedge io_clk);
    for (int i = 0; i < 8; i++) begin
      io_rx = (i < 3);
      repeat (CPB) @(negedge io_clk);
    end
    io_rx = 1'b0;
    repeat (CPB) @(negedge io_clk);
    io_rx = 1'b1;
    repeat (CPB) @(negedge io_clk);
    settle();
    checks++;
    if (n_fe - f0 !== 1) begin
      errors++;
      $display("FAIL par_ferr got %0d want 1", n_fe - f0);
    end
`endif
  endtask

  task automatic test_async_reset();
    bif.blk_ready = 1'b0;
    send_byte(8'h4B, 1'b1);
    for (int i = 0; i < 16; i++) send_byte(8'h3C, 1'b1);
    settle();
    checks++;
    if (bif.blk_valid !== 1'b1) begin
      errors++;
      $display("FAIL ar_pre got %b want 1", bif.blk_valid);
    end
    #2 io_reset = 1'b0;
    #1;
    checks++;
    if (bif.blk_valid !== 1'b0 || bif.blk_data !== 128'h0 ||
        bif.blk_is_key !== 1'b0) begin
      errors++;
      $display("FAIL ar_drop got v=%b d=%h k=%b want 0 0 0",
               bif.blk_valid, bif.blk_data, bif.blk_is_key);
    end
    repeat (3) @(negedge io_clk);
    io_reset = 1'b1;
    repeat (5) @(negedge io_clk);
  endtask

  initial begin
    bif.blk_ready = 1'b0;
    test_reset();
    test_key_block();
    test_backpressure();
    test_framing();
    test_cmd_glitch();
    test_timeout();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_block_rx.md
# uart_block_rx

- Receives the serial host stream arriving on the `io_rx` input pad and assembles framed commands into 128-bit AES key or plaintext blocks.
- Hands each block to the masked AES core over a valid/ready handshake.
- Sits directly downstream of the `io_rx` pad cell, inside the core.
- Handles metastability, bit timing, framing and error flags, so the AES datapath sees only complete blocks.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 16: `io_clk` cycles per UART bit; must be ≥ 4.
- `TIMEOUT_BYTES`, default 4: idle byte-times allowed between bytes of one command before the command is aborted.

Ports:
- `io_clk`  in  1  sole clock.
- `io_reset`  in  1  asynchronous, active-low reset.
- `io_rx`  in  1  raw serial input from the pad; asynchronous to `io_clk`; idles high.
- `blk_valid`  out  1  a block is presented.
- `blk_ready`  in  1  consumer accepts the block.
- `blk_data`  out  128  block contents; byte 0 received lands in [127:120].
- `blk_is_key`  out  1  1 = key block, 0 = plaintext block.
- `frame_err`  out  1  one-cycle pulse: bad stop bit or parity.
- `cmd_err`  out  1  one-cycle pulse: unknown command byte, or inter-byte timeout.
- `overrun`  out  1  one-cycle pulse: byte dropped while a block was held.

## Operation

**Input synchronisation**
- `io_rx` passes through a 2-flop synchroniser reset to 1.
- All logic uses the synchronised signal.

**Bit FSM:** IDLE → START → DATA → (PARITY) → STOP → IDLE.
- IDLE: a synchronised falling edge starts a counter.
- START: at count `CLKS_PER_BIT/2` the line must still be low; otherwise the edge was a glitch and the FSM returns to IDLE with no flag.
- DATA: 8 bits sampled at mid-bit, LSB first.
- STOP: a sample of 1 delivers the byte to the frame FSM; a sample of 0 pulses `frame_err` and discards the byte.
- After STOP the FSM returns to IDLE at the mid-bit of the stop bit, so back-to-back frames are accepted.

**Frame FSM:** WAIT_CMD → LOAD → HOLD.
- WAIT_CMD:
  - 0x4B ('K') sets the key flag and goes to LOAD.
  - 0x50 ('P') clears the key flag and goes to LOAD.
  - Any other byte pulses `cmd_err` and stays in WAIT_CMD.
- LOAD:
  - Each byte shifts into the block register; a 4-bit counter counts 0..15.
  - The 16th byte moves the FSM to HOLD.
  - A `frame_err` in LOAD aborts the command: go to WAIT_CMD, counter cleared.
  - No byte completed within `TIMEOUT_BYTES*10*CLKS_PER_BIT` cycles of the previous one pulses `cmd_err` and returns to WAIT_CMD.
- HOLD:
  - `blk_valid`=1; `blk_data` and `blk_is_key` are stable.
  - `blk_valid && blk_ready` returns the FSM to WAIT_CMD on the next cycle.
  - Any byte completing while in HOLD pulses `overrun` and is dropped.
  - The bit FSM keeps running in HOLD.

**Flag collisions**
- `frame_err`, `cmd_err` and `overrun` are independent.
- A timeout and a byte completing in the same cycle: the byte wins and the timer restarts.

## Timing

**Reset values**
- `blk_valid`=0, `blk_data`=0, `blk_is_key`=0, all error pulses 0.
- Synchroniser = 1.
- Both FSMs in IDLE/WAIT_CMD.

**Asserting `io_reset` mid-frame**
- Drops `blk_valid` immediately (asynchronous).
- Discards any partial byte or block.

**Latency**
- The byte is delivered 2 cycles of synchroniser delay plus 9.5 bit-times after the start edge.
- `blk_valid` rises the cycle after the 16th data byte is delivered.

**Handshake**
- `blk_valid` never drops without acceptance.
- `blk_ready` may be high before `blk_valid`; the transfer occurs in the first cycle both are high.
- `blk_valid` falls the following cycle; the minimum gap between blocks is 17 byte-times.

**Error pulses**
- Exactly one cycle wide, registered.

**Counters**
- Bit-timing counter width `$clog2(CLKS_PER_BIT)`; it wraps at `CLKS_PER_BIT-1`.
- Timeout counter saturates; it is cleared on each byte delivery and on leaving LOAD.

## Configuration

`UART_RX_PARITY_EN`
- **Defined:** the frame carries an even-parity bit after the data bits, sampled at mid-bit in the PARITY state.
  - Mismatch pulses `frame_err` and discards the byte, with the same abort rules as a bad stop bit.
  - Frame length is 11 bit-times, and the timeout uses 11 instead of 10.
- **Undefined:** the PARITY state and its logic are absent; frames are 8N1.

## Structure

**Shared package `aes_io_pkg`**
- Command byte constants `CMD_KEY`=8'h4B and `CMD_PT`=8'h50.
- Frame-FSM and bit-FSM state enums.
- `BLOCK_BYTES`=16.

**Sub-module `uart_rx_byte`**
- Contains the synchroniser and the bit FSM.
- Outputs a byte plus a one-cycle `byte_valid`, and a `byte_err`.
- `uart_block_rx` contains the frame FSM, block register, timeout and flags.

## Test plan

1. **Reset:** hold `io_reset`=0 for 5 cycles with `io_rx` toggling → all outputs 0, and no pulses after release with a quiet line.
2. **Key block:** send 0x4B then bytes 0x00..0x0F, `blk_ready`=1 → one `blk_valid` cycle with `blk_data`=128'h000102…0F and `blk_is_key`=1.
3. **Backpressure:** send 'P' + 16×0xA5 with `blk_ready`=0, then one extra byte 0x11 → `blk_valid` held with data stable and one `overrun` pulse; after `blk_ready`=1 for one cycle, `blk_valid`=0.
4. **Framing:** send 'P', 3 bytes, then a byte with stop bit 0 → `frame_err` pulse and no block; a following valid 'K'+16 bytes produces a correct block.
5. **Command and glitch:** send 0x41 → `cmd_err` pulse; a 2-cycle low glitch on `io_rx` → no byte and no flags.
6. **Timeout:** send 'K' + 5 bytes, then idle 5 byte-times → `cmd_err` pulse; with `UART_RX_PARITY_EN` defined, a byte with flipped parity → `frame_err`.
